// File: rtl/my_cpu_pkg.sv
// Shared CPU definitions: exception codes and debug trace entry sizing.
package my_cpu_pkg;

   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0B;

   // Trace entry layout is {pc, wnum, wdata}.
   function automatic int trace_w(input int pc_w, input int raddr_w, input int data_w);
      return pc_w + raddr_w + data_w;
   endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular debug-trace FIFO with one extra pointer bit to tell full from empty.
module wb_trace_fifo
   import my_cpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             do_push, do_pop;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

   // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds alongside it.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop)  rp <= rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: register-file write, exception/ertn flush, ERA/ECODE and a back-pressured trace FIFO.
module wb_commit_unit
   import my_cpu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 32,
   parameter int RADDR_W     = 5,
   parameter int TRACE_DEPTH = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               me_valid,
   input  logic [PC_W-1:0]    me_pc,
   input  logic               me_gr_we,
   input  logic [RADDR_W-1:0] me_dest,
   input  logic [DATA_W-1:0]  me_result,
   input  logic               me_ex,
   input  logic [5:0]         me_ecode,
   input  logic               me_ertn,
   input  logic [PC_W-1:0]    csr_eentry,
   output logic               wb_allow_in,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [RADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0]  wb_fwd_data,
   output logic               wb_flush,
   output logic [PC_W-1:0]    wb_flush_pc,
   output logic [PC_W-1:0]    csr_era,
   output logic [5:0]         csr_ecode,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [PC_W-1:0]    trace_pc,
   output logic [RADDR_W-1:0] trace_wnum,
   output logic [DATA_W-1:0]  trace_wdata
);

   localparam int TW = trace_w(PC_W, RADDR_W, DATA_W);

   logic               wb_valid;
   logic [PC_W-1:0]    pc;
   logic               gr_we, ex, ertn;
   logic [RADDR_W-1:0] dest;
   logic [DATA_W-1:0]  result;
   logic [5:0]         ecode;

   logic          wr_ok, ready_go, commit, fifo_full, fifo_empty, trace_pop;
   logic [TW-1:0] fifo_dout;

   assign wr_ok       = wb_valid && gr_we && !ex && !ertn && (dest != '0);
   assign trace_valid = !fifo_empty;
   assign trace_pop   = trace_valid && trace_ready;
   assign ready_go    = !wr_ok || !fifo_full || trace_pop;
   assign wb_allow_in = !wb_valid || ready_go;
   assign commit      = wb_valid && ready_go;

   assign rf_we       = wr_ok && ready_go;
   assign rf_waddr    = wb_valid ? dest : '0;
   assign rf_wdata    = wb_valid ? result : '0;
   assign wb_dest     = wr_ok ? dest : '0;
   assign wb_fwd_data = wb_valid ? result : '0;

   // ex wins over ertn when both are set.
   assign wb_flush    = commit && (ex || ertn);
   assign wb_flush_pc = !wb_flush ? '0 : (ex ? csr_eentry : csr_era);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_valid  <= 1'b0;
         csr_era   <= '0;
         csr_ecode <= '0;
      end else begin
         if (wb_allow_in) wb_valid <= me_valid && !wb_flush;
         if (wb_flush && ex) begin
            csr_era   <= pc;
            csr_ecode <= ecode;
         end
      end
   end

   // Payload is not reset; every consumer masks it with wb_valid.
   always_ff @(posedge clk) begin
      if (me_valid && wb_allow_in && !wb_flush) begin
         pc     <= me_pc;
         gr_we  <= me_gr_we;
         dest   <= me_dest;
         result <= me_result;
         ex     <= me_ex;
         ecode  <= me_ecode;
         ertn   <= me_ertn;
      end
   end

   wb_trace_fifo #(.WIDTH(TW), .DEPTH(TRACE_DEPTH)) u_trace_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (rf_we),
      .din    ({pc, dest, result}),
      .full   (fifo_full),
      .pop    (trace_pop),
      .dout   (fifo_dout),
      .empty  (fifo_empty)
   );

   assign {trace_pc, trace_wnum, trace_wdata} = trace_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: writes, back-pressure, dest=0, exception/ertn flush, async reset.
module tb_wb_commit_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        me_valid, me_gr_we, me_ex, me_ertn, trace_ready;
   logic [31:0] me_pc, me_result, csr_eentry;
   logic [4:0]  me_dest;
   logic [5:0]  me_ecode;
   logic        wb_allow_in, rf_we, wb_flush, trace_valid;
   logic [4:0]  rf_waddr, wb_dest, trace_wnum;
   logic [31:0] rf_wdata, wb_fwd_data, wb_flush_pc, csr_era, trace_pc, trace_wdata;
   logic [5:0]  csr_ecode;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   wb_commit_unit #(.DATA_W(32), .PC_W(32), .RADDR_W(5), .TRACE_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn),
      .me_valid(me_valid), .me_pc(me_pc), .me_gr_we(me_gr_we), .me_dest(me_dest),
      .me_result(me_result), .me_ex(me_ex), .me_ecode(me_ecode), .me_ertn(me_ertn),
      .csr_eentry(csr_eentry), .wb_allow_in(wb_allow_in), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_dest(wb_dest), .wb_fwd_data(wb_fwd_data),
      .wb_flush(wb_flush), .wb_flush_pc(wb_flush_pc), .csr_era(csr_era), .csr_ecode(csr_ecode),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
      .trace_wnum(trace_wnum), .trace_wdata(trace_wdata)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
      me_valid = 1'b1; me_pc = pc; me_gr_we = 1'b1; me_dest = d; me_result = r;
      me_ex = 1'b0; me_ertn = 1'b0; me_ecode = '0;
   endtask

   task automatic idle();
      me_valid = 1'b0; me_gr_we = 1'b0; me_ex = 1'b0; me_ertn = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; trace_ready = 1'b0; csr_eentry = 32'h1c008000;
      me_pc = '0; me_dest = '0; me_result = '0; me_ecode = '0;
      idle();
      #12;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_trace_valid", trace_valid, 0);
      chk("rst_allow_in", wb_allow_in, 1);
      resetn = 1'b1;

      // single write, trace head appears the cycle after commit
      trace_ready = 1'b1;
      tick();
      drive_wr(32'h1c000000, 5'd5, 32'hDEADBEEF);
      tick();
      idle(); #1;
      chk("w1_rf_we", rf_we, 1);
      chk("w1_waddr", rf_waddr, 5);
      chk("w1_wdata", rf_wdata, 32'hDEADBEEF);
      chk("w1_wb_dest", wb_dest, 5);
      chk("w1_trace_early", trace_valid, 0);
      tick();
      chk("w1_rf_we_off", rf_we, 0);
      chk("w1_trace_valid", trace_valid, 1);
      chk("w1_trace_pc", trace_pc, 32'h1c000000);
      chk("w1_trace_wnum", trace_wnum, 5);
      chk("w1_trace_wdata", trace_wdata, 32'hDEADBEEF);
      tick();
      chk("w1_trace_drained", trace_valid, 0);

      // fill the FIFO, fifth write stalls until the consumer pops
      trace_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive_wr(32'h1c000100 + 32'(4 * i), 5'(i), 32'h100 + 32'(i));
         tick();
      end
      idle(); #1;
      chk("stall_allow_in", wb_allow_in, 0);
      chk("stall_rf_we", rf_we, 0);
      chk("stall_wb_dest", wb_dest, 5);
      tick();
      chk("stall2_allow_in", wb_allow_in, 0);
      chk("stall2_wb_dest", wb_dest, 5);
      trace_ready = 1'b1; #1;
      chk("unstall_allow_in", wb_allow_in, 1);
      chk("unstall_rf_we", rf_we, 1);
      chk("unstall_waddr", rf_waddr, 5);
      for (int k = 1; k <= 5; k++) begin
         chk("drain_valid", trace_valid, 1);
         chk("drain_wnum", trace_wnum, 5'(k));
         chk("drain_wdata", trace_wdata, 32'h100 + 32'(k));
         chk("drain_pc", trace_pc, 32'h1c000100 + 32'(4 * k));
         tick();
      end
      chk("drain_empty", trace_valid, 0);

      // dest 0 never writes
      drive_wr(32'h1c000200, 5'd0, 32'h1234);
      tick();
      idle(); #1;
      chk("r0_rf_we", rf_we, 0);
      chk("r0_wb_dest", wb_dest, 0);
      tick();
      chk("r0_trace", trace_valid, 0);

      // exception; the ME instruction presented in the flush cycle is dropped
      me_valid = 1'b1; me_pc = 32'h1c000010; me_gr_we = 1'b1; me_dest = 5'd7;
      me_result = 32'h77; me_ex = 1'b1; me_ecode = 6'h0B; me_ertn = 1'b0;
      tick();
      drive_wr(32'h1c000020, 5'd9, 32'h99); #1;
      chk("ex_flush", wb_flush, 1);
      chk("ex_flush_pc", wb_flush_pc, 32'h1c008000);
      chk("ex_rf_we", rf_we, 0);
      tick();
      idle(); #1;
      chk("ex_flush_off", wb_flush, 0);
      chk("ex_era", csr_era, 32'h1c000010);
      chk("ex_ecode", csr_ecode, 6'h0B);
      chk("ex_drop_rf_we", rf_we, 0);
      chk("ex_drop_dest", wb_dest, 0);
      chk("ex_no_trace", trace_valid, 0);

      // ertn returns to ERA and leaves CSRs alone
      me_valid = 1'b1; me_pc = 32'h1c000030; me_gr_we = 1'b0; me_ertn = 1'b1;
      tick();
      idle(); #1;
      chk("ertn_flush", wb_flush, 1);
      chk("ertn_flush_pc", wb_flush_pc, 32'h1c000010);
      tick();
      chk("ertn_flush_off", wb_flush, 0);
      chk("ertn_era", csr_era, 32'h1c000010);
      chk("ertn_ecode", csr_ecode, 6'h0B);

      // async reset with 3 entries queued and a write pending in the stage
      trace_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_wr(32'h1c000300 + 32'(4 * i), 5'(i + 10), 32'h300 + 32'(i));
         tick();
      end
      idle(); #1;
      chk("pre_rst_wb_dest", wb_dest, 14);
      chk("pre_rst_trace", trace_valid, 1);
      #1 resetn = 1'b0; #1;
      chk("arst_rf_we", rf_we, 0);
      chk("arst_wb_dest", wb_dest, 0);
      chk("arst_trace_valid", trace_valid, 0);
      chk("arst_trace_pc", trace_pc, 0);
      chk("arst_rf_wdata", rf_wdata, 0);
      chk("arst_era", csr_era, 0);
      chk("arst_ecode", csr_ecode, 0);
      chk("arst_flush", wb_flush, 0);
      #3 resetn = 1'b1;
      tick();
      chk("post_rst_trace", trace_valid, 0);
      chk("post_rst_rf_we", rf_we, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
